axi_read_arb_master: RTL and testbench
======================================

// Module: axi_read_arb_master
// PURPOSE
//  Multi-requester AXI4 read master: round-robin arbitrates N_REQ clients (e.g. icache, dcache),
//  issues one INCR burst of BEATS beats per grant, assembles beats into a line buffer, and
//  returns the line with an error flag under a valid/ready handshake. One burst outstanding.
//  Sits between cache refill logic and the shared axi_read_if fabric port.
// PARAMETERS
//  N_REQ     2       number of requesters (>=1)
//  ADDR_W    32      address width
//  DATA_W    32      AXI rdata width (8..1024, power of two)
//  BEATS     4       beats per burst; arlen = BEATS-1 (1..256)
//  LINE_W    BEATS*DATA_W  derived, resp_data width
// PORTS
//  clk         in   1               clock
//  rst_n       in   1               async active-low reset
//  req_valid   in   N_REQ           per-client request; held until req_ready
//  req_addr    in   N_REQ*ADDR_W    client i address at [i*ADDR_W +: ADDR_W]
//  req_ready   out  N_REQ           one-hot 1-cycle accept pulse
//  resp_valid  out  N_REQ           one-hot; held until matching resp_ready
//  resp_ready  in   N_REQ           client response accept
//  resp_data   out  LINE_W          beat k at [k*DATA_W +: DATA_W]
//  resp_err    out  1               1 = any beat rresp!=OKAY or burst-length mismatch
//  arvalid/arready/araddr[ADDR_W]/arlen[8]/arsize[3]/arburst[2]   AXI AR channel
//  rvalid/rready/rdata[DATA_W]/rresp[2]/rlast                      AXI R channel
// BEHAVIOUR
//  Reset: rst_n asynchronous, active-low; clock clk. All outputs 0, FSM IDLE, rr_ptr=0,
//   beat_cnt=0, line buffer 0, resp_err=0.
//  FSM: IDLE -> AR -> R -> RESP -> IDLE.
//   IDLE: if any req_valid, grant first set bit searching from rr_ptr upward (wrap at N_REQ);
//    pulse req_ready[g], latch g and req_addr[g]; next AR. rr_ptr <= (g+1) mod N_REQ.
//   AR: arvalid=1, araddr=latched addr, arlen=BEATS-1, arsize=log2(DATA_W/8), arburst=2'b01;
//    stable until arready; on arvalid&arready -> R (arvalid drops next cycle).
//   R: rready=1. Each rvalid&rready: store rdata at beat_cnt slot while beat_cnt<BEATS,
//    beat_cnt++ (saturate at BEATS); err |= (rresp!=2'b00).
//    rlast beat with beat_cnt==BEATS-1 -> RESP, clean.
//    rlast early (beat_cnt<BEATS-1) -> err=1, RESP; unfilled slots keep previous contents.
//    beat beyond BEATS (no rlast yet) -> err=1, data discarded, stay in R until rlast.
//   RESP: resp_valid[g]=1, resp_data/resp_err stable; on resp_valid[g]&resp_ready[g] -> IDLE,
//    beat_cnt and err cleared. New grant no earlier than cycle after response accept.
//  Latency (zero-wait fabric): req_valid@T0 -> req_ready@T0 (comb from IDLE) -> arvalid@T1
//   -> first beat earliest T2 -> resp_valid one cycle after last beat.
//  Boundaries: ungranted clients keep req_valid asserted, no pulse; req_valid dropped while
//   ungranted is legal; N_REQ=1 degenerates to fixed grant; rlast while beat_cnt saturated ok.
//  Reset mid-burst: immediate return to IDLE, outputs zero; fabric side must also be reset.
// TESTING
//  1 client0 addr 0x100, BEATS=4, beats A0..A3 OKAY -> araddr=0x100 arlen=3 arsize=2,
//    resp_data={A3,A2,A1,A0}, resp_err=0, resp_valid[0] one cycle after rlast.
//  2 client0 and client1 both valid at reset exit -> grant 0 then 1, then 0 again if both
//    re-request (round-robin), never two req_ready bits in one cycle.
//  3 arready held low 5 cycles -> arvalid/araddr stable throughout, single AR handshake.
//  4 beat 2 rresp=SLVERR -> all 4 beats captured, resp_err=1; early rlast on beat 1 -> err=1.
//  5 resp_ready low 10 cycles -> resp_valid/resp_data held; no new AR issued meanwhile.
//  6 rst_n asserted after beat 1 -> all outputs 0 asynchronously; fresh request completes.

Source files
------------

// File: rtl/axi_read_arb_master.sv
// ---------------------------------------------------------------------------
// axi_read_arb_master
//
// Purpose:
//   Shares one AXI4 read port among N_REQ refill clients (icache, dcache...).
//   A round-robin arbiter picks one client at a time. Each grant issues a
//   single INCR burst of BEATS beats. The beats are assembled into a line
//   buffer, and the line is handed back to the granted client together with
//   an error flag. Only one burst is ever in flight.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   req_valid       per-client request, held by the client until req_ready
//   req_addr        client i address at [i*ADDR_W +: ADDR_W]
//   req_ready       one-hot, single-cycle accept pulse (combinational in IDLE)
//   resp_valid      one-hot, held until the granted client raises resp_ready
//   resp_ready      per-client response accept
//   resp_data       assembled line, beat k at [k*DATA_W +: DATA_W]
//   resp_err        1 = some beat had rresp != OKAY, or the burst length was wrong
//   ar*             AXI4 read address channel (master side)
//   r*              AXI4 read data channel (master side)
// ---------------------------------------------------------------------------
module axi_read_arb_master #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int LINE_W = BEATS * DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          resp_valid,
  input  logic [N_REQ-1:0]          resp_ready,
  output logic [LINE_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDR_W-1:0]         araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_W-1:0]         rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(BEATS + 1);

  localparam logic [PTR_W:0]   NREQ_C  = (PTR_W + 1)'(N_REQ);
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);
  localparam logic [7:0]       ARLEN_C = 8'(BEATS - 1);
  localparam logic [2:0]       SIZE_C  = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]    gnt_reg, gnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
  logic                err_reg, err_next;
  logic                beat_wr;

  // -------------------------------------------------------------------------
  // Round-robin search. The request vector is rotated right by rr_ptr, so
  // bit k of req_rot belongs to client (rr_ptr + k) mod N_REQ. The lowest set
  // bit of the rotated vector is the winner.
  // -------------------------------------------------------------------------
  logic [2*N_REQ-1:0]  req_dbl;
  logic [N_REQ-1:0]    req_rot;
  logic                grant_found;
  logic [PTR_W-1:0]    grant_off;
  logic [PTR_W:0]      grant_sum;
  logic [PTR_W-1:0]    grant_idx;
  logic [PTR_W:0]      grant_inc;
  logic [PTR_W-1:0]    grant_ptr;
  logic [ADDR_W-1:0]   grant_addr;

  assign req_dbl = {req_valid, req_valid} >> rr_ptr_reg;
  assign req_rot = req_dbl[N_REQ-1:0];

  always_comb begin
    grant_found = 1'b0;
    grant_off   = '0;
    // Walk downward so that the lowest set bit is the one left standing.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_found = 1'b1;
        grant_off   = k[PTR_W-1:0];
      end
    end
  end

  assign grant_sum  = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
  assign grant_idx  = (grant_sum >= NREQ_C) ? PTR_W'(grant_sum - NREQ_C)
                                            : grant_sum[PTR_W-1:0];
  assign grant_inc  = {1'b0, grant_idx} + (PTR_W + 1)'(1);
  assign grant_ptr  = (grant_inc >= NREQ_C) ? '0 : grant_inc[PTR_W-1:0];
  assign grant_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];

  // -------------------------------------------------------------------------
  // State register and control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      gnt_reg      <= '0;
      addr_reg     <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      gnt_reg      <= gnt_next;
      addr_reg     <= addr_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic and AXI outputs. AXI fields are driven only while the
  // matching channel is active so that every output reads 0 outside it.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    gnt_next      = gnt_reg;
    addr_next     = addr_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    arvalid       = 1'b0;
    araddr        = '0;
    arlen         = '0;
    arsize        = '0;
    arburst       = '0;
    rready        = 1'b0;
    beat_wr       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (grant_found) begin
          gnt_next    = grant_idx;
          addr_next   = grant_addr;
          rr_ptr_next = grant_ptr;
          state_next  = AR;
        end
      end

      AR: begin
        arvalid = 1'b1;
        araddr  = addr_reg;
        arlen   = ARLEN_C;
        arsize  = SIZE_C;
        arburst = 2'b01;
        if (arready) begin
          state_next = R;
        end
      end

      R: begin
        rready = 1'b1;
        if (rvalid) begin
          // Beats past the line are dropped and flagged; the counter
          // saturates at BEATS so it never aliases onto a real slot.
          if (beat_cnt_reg < BEATS_C) begin
            beat_wr       = 1'b1;
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end else begin
            err_next = 1'b1;
          end
          if (rresp != 2'b00) begin
            err_next = 1'b1;
          end
          if (rlast) begin
            // Only an rlast on exactly the final slot is a clean burst;
            // early and saturated cases are both length errors.
            if (beat_cnt_reg != LAST_C) begin
              err_next = 1'b1;
            end
            state_next = RESP;
          end
        end
      end

      RESP: begin
        if (resp_ready[gnt_reg]) begin
          beat_cnt_next = '0;
          err_next      = 1'b0;
          state_next    = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Line buffer: one register slot per beat. Slots not written by a short
  // burst keep whatever the previous line left there.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
    logic [DATA_W-1:0] slot_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= '0;
      end else if (beat_wr && (beat_cnt_reg == CNT_W'(gi))) begin
        slot_reg <= rdata;
      end
    end

    assign resp_data[gi*DATA_W +: DATA_W] = slot_reg;
  end

  // -------------------------------------------------------------------------
  // Client-side handshakes. req_ready is qualified with rst_n so that it
  // stays low while reset is held, even though requests may already be up.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_client
    assign req_ready[gi]  = rst_n && (state_reg == IDLE) && grant_found &&
                            (grant_idx == PTR_W'(gi));
    assign resp_valid[gi] = (state_reg == RESP) && (gnt_reg == PTR_W'(gi));
  end

  assign resp_err = err_reg;

endmodule

// File: tb/tb_axi_read_arb_master.sv
// ---------------------------------------------------------------------------
// tb_axi_read_arb_master
//
// Directed bench for axi_read_arb_master (N_REQ=2, DATA_W=32, BEATS=4).
// The initial block plays both the clients and the AXI slave, one burst at a
// time. Expected lines are pushed to a scoreboard queue when a request is
// accepted and popped when the DUT presents its response.
// ---------------------------------------------------------------------------
module tb_axi_read_arb_master;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;
  localparam int LINE_W = BEATS * DATA_W;

  logic                    clk;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        resp_valid;
  logic [N_REQ-1:0]        resp_ready;
  logic [LINE_W-1:0]       resp_data;
  logic                    resp_err;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_W-1:0]       araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_W-1:0]       rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  axi_read_arb_master #(
    .N_REQ (N_REQ),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .BEATS (BEATS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          client;
    logic [127:0] data;
    logic        err;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model_line;
  int           checks;
  int           errors;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] addr, input int k);
    return (addr * 32'd3) + (32'h0101_0101 * 32'(k)) + 32'h5A00_0000;
  endfunction

  // One complete transaction for client c. err_beat < 0 means all OKAY;
  // nbeats != BEATS exercises the early/late rlast cases; hold is the number
  // of cycles resp_ready is withheld.
  task automatic run_txn(input int c, input logic [31:0] addr, input int ar_wait,
                         input int err_beat, input int nbeats, input int hold);
    logic [1:0]   oh;
    logic [127:0] snap;
    logic         snap_err;
    logic         stable;
    exp_t         e;
    exp_t         got;
    int           n;

    oh = 2'b01 << c;
    req_valid[c] = 1'b1;
    req_addr[c*ADDR_W +: ADDR_W] = addr;
    #1;
    n = 0;
    while (req_ready !== oh && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_grant", 128'(req_ready), 128'(oh));
    if (req_ready !== oh) begin
      req_valid[c] = 1'b0;
      return;
    end

    e.client = c;
    e.err    = (nbeats != BEATS) || (err_beat >= 0 && err_beat < nbeats);
    for (int k = 0; k < nbeats && k < BEATS; k++) begin
      model_line[k*DATA_W +: DATA_W] = beat_data(addr, k);
    end
    e.data = model_line;
    sb.push_back(e);

    tick();
    req_valid[c] = 1'b0;
    #1;
    chk("ar_valid", 128'(arvalid), 128'(1));
    chk("ar_addr", 128'(araddr), 128'(addr));
    chk("ar_len", 128'(arlen), 128'(3));
    chk("ar_size", 128'(arsize), 128'(2));
    chk("ar_burst", 128'(arburst), 128'(1));
    chk("req_ready_busy", 128'(req_ready), 128'(0));

    stable = 1'b1;
    for (int i = 0; i < ar_wait; i++) begin
      tick();
      if (arvalid !== 1'b1 || araddr !== addr || rready !== 1'b0) stable = 1'b0;
    end
    if (ar_wait > 0) chk("ar_stable", 128'(stable), 128'(1));

    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("ar_drop", 128'(arvalid), 128'(0));
    chk("r_ready", 128'(rready), 128'(1));

    for (int k = 0; k < nbeats; k++) begin
      rvalid = 1'b1;
      rdata  = beat_data(addr, k);
      rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      rlast  = (k == nbeats - 1);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;

    chk("resp_valid_latency", 128'(resp_valid), 128'(oh));
    chk("r_ready_drop", 128'(rready), 128'(0));

    snap     = resp_data;
    snap_err = resp_err;
    stable   = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (resp_valid !== oh || resp_data !== snap || resp_err !== snap_err ||
          arvalid !== 1'b0 || req_ready !== 2'b00) stable = 1'b0;
    end
    if (hold > 0) chk("resp_hold", 128'(stable), 128'(1));

    resp_ready[c] = 1'b1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 128'(sb.size()), 128'(1));
    end else begin
      got = sb.pop_front();
      chk("resp_client", 128'(resp_valid), 128'(2'b01 << got.client));
      chk("resp_data", 128'(resp_data), got.data);
      chk("resp_err", 128'(resp_err), 128'(got.err));
    end
    $display("txn client=%0d addr=%08h beats=%0d err=%0b data=%032h",
             c, addr, nbeats, resp_err, resp_data);
    tick();
    resp_ready[c] = 1'b0;
    chk("resp_valid_clear", 128'(resp_valid), 128'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    logic all_zero;
    all_zero = (req_ready === '0) && (resp_valid === '0) && (resp_data === '0) &&
               (resp_err === 1'b0) && (arvalid === 1'b0) && (araddr === '0) &&
               (arlen === '0) && (arsize === '0) && (arburst === '0) && (rready === 1'b0);
    chk(tag, 128'(all_zero), 128'(1));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model_line = '0;
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_addr   = {32'h0000_0200, 32'h0000_0100};
    resp_ready = '0;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rdata      = '0;
    rresp      = 2'b00;
    rlast      = 1'b0;

    // Reset held with both clients already requesting.
    repeat (3) tick();
    chk_all_zero("reset_outputs");
    chk("reset_req_ready", 128'(req_ready), 128'(0));
    chk("reset_resp_data", 128'(resp_data), 128'(0));

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rr_first_grant", 128'(req_ready), 128'(2'b01));

    // Round-robin: 0, then 1 while 0 re-requests, then 0 again.
    run_txn(0, 32'h0000_0100, 0, -1, 4, 0);
    req_valid[0] = 1'b1;
    req_addr[0 +: ADDR_W] = 32'h0000_0300;
    run_txn(1, 32'h0000_0200, 0, -1, 4, 0);
    req_valid[1] = 1'b1;
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_0400;
    run_txn(0, 32'h0000_0300, 0, -1, 4, 0);

    // arready held low for 5 cycles.
    run_txn(1, 32'h0000_0400, 5, -1, 4, 0);

    // SLVERR on beat 2; early rlast on beat 1; overrun burst of 6 beats.
    run_txn(0, 32'h0000_0500, 0, 2, 4, 0);
    run_txn(1, 32'h0000_0600, 0, -1, 2, 0);
    run_txn(0, 32'h0000_0700, 0, -1, 6, 0);

    // Response withheld for 10 cycles while the other client is waiting.
    req_valid[0] = 1'b1;
    req_addr[0 +: ADDR_W] = 32'h0000_0900;
    run_txn(1, 32'h0000_0800, 0, -1, 4, 10);
    run_txn(0, 32'h0000_0900, 0, -1, 4, 0);

    // Reset in the middle of a burst, after the first beat was stored.
    req_valid[1] = 1'b1;
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_0A00;
    #1;
    chk("mid_grant", 128'(req_ready), 128'(2'b10));
    tick();
    req_valid[1] = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    rlast  = 1'b0;
    tick();
    rvalid = 1'b0;
    chk("mid_rready", 128'(rready), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset_outputs");
    model_line = '0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh requests complete normally after the reset.
    run_txn(1, 32'h0000_0B00, 0, -1, 4, 0);
    run_txn(0, 32'h0000_0C00, 1, -1, 4, 2);

    chk("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
